card_shoe: RTL and testbench

Randomised 52-card shoe that supplies cards to both hand controllers of the blackjack game. It sits directly upstream of the game FSM. It accepts one draw request at a time and returns a single, unique card after a bounded search. It tracks dealt cards so no card repeats until the shoe is reshuffled. A free-running LFSR generates the draw order, and player button timing perturbs it to provide entropy.

---
 rtl/card_shoe_if.sv | 26 ++
 rtl/card_shoe.sv | 216 +++++++++++++++++++++
 tb/tb_card_shoe.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/card_shoe_if.sv
// card_shoe_if -- request/response bundle between the blackjack game FSM and
// the card shoe.
//   master (game side): drives i_req, i_shuffle, i_entropy; observes the rest.
//   slave  (shoe side): observes the requests; drives o_ready, o_card_valid,
//                       o_rank[3:0], o_suit[1:0], o_remaining[5:0], o_reshuffled.
interface card_shoe_if;
    logic       i_req;
    logic       i_shuffle;
    logic       i_entropy;
    logic       o_ready;
    logic       o_card_valid;
    logic [3:0] o_rank;
    logic [1:0] o_suit;
    logic [5:0] o_remaining;
    logic       o_reshuffled;

    modport master (
        output i_req, i_shuffle, i_entropy,
        input  o_ready, o_card_valid, o_rank, o_suit, o_remaining, o_reshuffled
    );

    modport slave (
        input  i_req, i_shuffle, i_entropy,
        output o_ready, o_card_valid, o_rank, o_suit, o_remaining, o_reshuffled
    );
endinterface

// File: rtl/card_shoe.sv
// card_shoe -- randomised 52-card shoe feeding the blackjack hand controllers.
// A free-running 16-bit Galois LFSR picks the start index of each draw; a
// rising edge on the deal-button strobe folds a free-running cycle counter into
// the LFSR for entropy.
// Ports:
//   i_clk    rising-edge clock
//   i_reset  asynchronous, active-high reset
//   shoe     card_shoe_if.slave: i_req / i_shuffle / i_entropy in;
//            o_ready, o_card_valid, o_rank (1..13), o_suit (0..3),
//            o_remaining (0..52), o_reshuffled out
// Build option:
//   CARD_SHOE_TRACK_EN defined   -> dealt-card bitmap, linear search for the
//                                   next free card, auto-reshuffle when empty.
//   CARD_SHOE_TRACK_EN undefined -> infinite shoe: every draw takes the LFSR
//                                   start card, o_remaining stays 52.
module card_shoe #(
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input logic        i_clk,
    input logic        i_reset,
    card_shoe_if.slave shoe
);
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam logic [5:0]  DECK      = 6'd52;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLEAR,
        S_SEARCH,
        S_PRESENT
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [15:0] cnt_q, cnt_d;
    logic        ent_q;
    logic [3:0]  srank_q, srank_d;  // rank/suit of the index under search
    logic [1:0]  ssuit_q, ssuit_d;
    logic [3:0]  rank_q, rank_d;    // presented card, held between pulses
    logic [1:0]  suit_q, suit_d;
`ifdef CARD_SHOE_TRACK_EN
    logic [5:0]  idx_q, idx_d;
    logic [5:0]  rem_q, rem_d;
    logic [51:0] dealt_q, dealt_d;
    logic        auto_q, auto_d;
`endif

    logic [5:0]  start_idx;
    logic [5:0]  start_base;
    logic [1:0]  start_suit;
    logic [3:0]  start_rank;
    logic [15:0] lfsr_step;
    logic [15:0] lfsr_mix;
    logic        load_start;

    // Start card from LFSR[5:0]; suit/rank found by range compares so the
    // search path never needs a divider.
    always_comb begin
        start_idx = (lfsr_q[5:0] < DECK) ? lfsr_q[5:0] : lfsr_q[5:0] - DECK;
        if (start_idx >= 6'd39) begin
            start_suit = 2'd3;
            start_base = 6'd39;
        end else if (start_idx >= 6'd26) begin
            start_suit = 2'd2;
            start_base = 6'd26;
        end else if (start_idx >= 6'd13) begin
            start_suit = 2'd1;
            start_base = 6'd13;
        end else begin
            start_suit = 2'd0;
            start_base = 6'd0;
        end
        start_rank = 4'(start_idx - start_base + 6'd1);
    end

    always_comb begin
        state_d    = state_q;
        srank_d    = srank_q;
        ssuit_d    = ssuit_q;
        rank_d     = rank_q;
        suit_d     = suit_q;
        load_start = 1'b0;
`ifdef CARD_SHOE_TRACK_EN
        idx_d      = idx_q;
        rem_d      = rem_q;
        dealt_d    = dealt_q;
        auto_d     = auto_q;
`endif
        cnt_d      = cnt_q + 16'd1;
        lfsr_step  = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : '0);
        lfsr_mix   = lfsr_q ^ cnt_q;
        // A reseed replaces the normal advance in that cycle.
        if (shoe.i_entropy && !ent_q) begin
            lfsr_d = (lfsr_mix == '0) ? LFSR_SEED : lfsr_mix;
        end else begin
            lfsr_d = lfsr_step;
        end

        case (state_q)
            S_IDLE: begin
                if (shoe.i_shuffle) begin
                    state_d = S_CLEAR;
`ifdef CARD_SHOE_TRACK_EN
                    auto_d  = 1'b0;
`endif
                end else if (shoe.i_req) begin
                    state_d    = S_SEARCH;
                    load_start = 1'b1;
`ifdef CARD_SHOE_TRACK_EN
                    // Empty shoe: refill first, start index is taken in CLEAR.
                    if (rem_q == '0) begin
                        state_d = S_CLEAR;
                        auto_d  = 1'b1;
                    end
`endif
                end
            end
            S_CLEAR: begin
                state_d = S_IDLE;
`ifdef CARD_SHOE_TRACK_EN
                dealt_d = '0;
                rem_d   = DECK;
                auto_d  = 1'b0;
                if (auto_q) begin
                    state_d    = S_SEARCH;
                    load_start = 1'b1;
                end
`endif
            end
            S_SEARCH: begin
`ifdef CARD_SHOE_TRACK_EN
                if (dealt_q[idx_q]) begin
                    if (idx_q == DECK - 6'd1) begin
                        idx_d   = '0;
                        srank_d = 4'd1;
                        ssuit_d = 2'd0;
                    end else begin
                        idx_d = idx_q + 6'd1;
                        if (srank_q == 4'd13) begin
                            srank_d = 4'd1;
                            ssuit_d = ssuit_q + 2'd1;
                        end else begin
                            srank_d = srank_q + 4'd1;
                        end
                    end
                end else begin
                    dealt_d = dealt_q | (52'd1 << idx_q);
                    rem_d   = rem_q - 6'd1;
                    rank_d  = srank_q;
                    suit_d  = ssuit_q;
                    state_d = S_PRESENT;
                end
`else
                rank_d  = srank_q;
                suit_d  = ssuit_q;
                state_d = S_PRESENT;
`endif
            end
            S_PRESENT: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase

        if (load_start) begin
            srank_d = start_rank;
            ssuit_d = start_suit;
`ifdef CARD_SHOE_TRACK_EN
            idx_d   = start_idx;
`endif
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= S_IDLE;
            lfsr_q  <= LFSR_SEED;
            cnt_q   <= '0;
            ent_q   <= 1'b0;
            srank_q <= '0;
            ssuit_q <= '0;
            rank_q  <= '0;
            suit_q  <= '0;
`ifdef CARD_SHOE_TRACK_EN
            idx_q   <= '0;
            rem_q   <= DECK;
            dealt_q <= '0;
            auto_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            cnt_q   <= cnt_d;
            ent_q   <= shoe.i_entropy;
            srank_q <= srank_d;
            ssuit_q <= ssuit_d;
            rank_q  <= rank_d;
            suit_q  <= suit_d;
`ifdef CARD_SHOE_TRACK_EN
            idx_q   <= idx_d;
            rem_q   <= rem_d;
            dealt_q <= dealt_d;
            auto_q  <= auto_d;
`endif
        end
    end

    assign shoe.o_ready      = (state_q == S_IDLE);
    assign shoe.o_card_valid = (state_q == S_PRESENT);
    assign shoe.o_reshuffled = (state_q == S_CLEAR);
    assign shoe.o_rank       = rank_q;
    assign shoe.o_suit       = suit_q;
`ifdef CARD_SHOE_TRACK_EN
    assign shoe.o_remaining  = rem_q;
`else
    assign shoe.o_remaining  = DECK;
`endif
endmodule

// File: tb/tb_card_shoe.sv
// tb_card_shoe -- self-checking bench for card_shoe. A reference model keeps
// the LFSR/counter per the shoe's rules plus a set of dealt cards, predicts
// each draw's card and latency, and checks them against the DUT. Build with or
// without CARD_SHOE_TRACK_EN.
module tb_card_shoe;
`ifdef CARD_SHOE_TRACK_EN
    localparam bit TRACK = 1'b1;
`else
    localparam bit TRACK = 1'b0;
`endif
    localparam logic [15:0] SEED = 16'hACE1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    card_shoe_if bus ();

    card_shoe #(.LFSR_SEED(SEED)) dut (
        .i_clk  (clk),
        .i_reset(rst),
        .shoe   (bus)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [15:0] m_lfsr;
    logic [15:0] m_cnt;
    logic        m_ent_prev;
    bit          m_dealt[52];
    int          m_rem = 52;

    function automatic logic [15:0] galois(input logic [15:0] x);
        return (x >> 1) ^ (x[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic logic [15:0] reseed(input logic [15:0] l, input logic [15:0] c);
        return ((l ^ c) == 16'h0000) ? SEED : (l ^ c);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_lfsr     <= SEED;
            m_cnt      <= 16'h0000;
            m_ent_prev <= 1'b0;
        end else begin
            m_lfsr     <= (bus.i_entropy && !m_ent_prev) ? reseed(m_lfsr, m_cnt) : galois(m_lfsr);
            m_cnt      <= m_cnt + 16'd1;
            m_ent_prev <= bus.i_entropy;
        end
    end

    function automatic void predict(input int start, output int idx, output int k);
        idx = start;
        k   = 1;
        while (m_dealt[idx] && k <= 52) begin
            idx = (idx + 1) % 52;
            k++;
        end
    endfunction

    function automatic int start_of(input logic [15:0] l);
        int v;
        v = int'(l[5:0]);
        return (v < 52) ? v : v - 52;
    endfunction

    task automatic clear_model();
        foreach (m_dealt[i]) m_dealt[i] = 1'b0;
        m_rem = 52;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- stimulus helpers ----------------
    initial begin
        bus.i_entropy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.i_entropy = ($urandom_range(0, 3) == 0);
        end
    end

    task automatic draw();
        int  n, start, idx, k, lat, resh_n;
        bit  empty;
        logic [15:0] l;
        @(posedge clk); #1;
        chk("ready_before_req", int'(bus.o_ready), 1);
        empty = TRACK && (m_rem == 0);
        l = m_lfsr;
        bus.i_req = 1'b1;
        @(posedge clk); #1;
        bus.i_req = 1'b0;
        if (empty) begin
            l = m_lfsr;  // auto-draw takes its start index in the refill cycle
            clear_model();
        end
        start = start_of(l);
        predict(start, idx, k);
        lat = (empty ? 2 : 1) + k;
        n = 1;
        resh_n = 0;
        forever begin
            @(negedge clk);
            if (bus.o_reshuffled && resh_n == 0) resh_n = n;
            if (bus.o_card_valid || n >= 60) break;
            @(posedge clk);
            n++;
        end
        chk("latency", n, lat);
        chk("rank", int'(bus.o_rank), idx % 13 + 1);
        chk("suit", int'(bus.o_suit), idx / 13);
        if (TRACK) begin
            m_dealt[idx] = 1'b1;
            m_rem--;
        end
        chk("remaining", int'(bus.o_remaining), m_rem);
        chk("reshuffle_cycle", resh_n, empty ? 1 : 0);
        @(negedge clk);
        chk("valid_single_pulse", int'(bus.o_card_valid), 0);
        chk("rank_hold", int'(bus.o_rank), idx % 13 + 1);
        chk("ready_after_valid", int'(bus.o_ready), 1);
    endtask

    task automatic do_shuffle();
        @(posedge clk); #1;
        chk("ready_before_shuffle", int'(bus.o_ready), 1);
        bus.i_shuffle = 1'b1;
        @(posedge clk); #1;
        bus.i_shuffle = 1'b0;
        @(negedge clk);
        chk("shuffle_pulse", int'(bus.o_reshuffled), 1);
        chk("shuffle_busy", int'(bus.o_ready), 0);
        @(negedge clk);
        chk("shuffle_ready_t2", int'(bus.o_ready), 1);
        chk("shuffle_pulse_end", int'(bus.o_reshuffled), 0);
        chk("shuffle_remaining", int'(bus.o_remaining), 52);
        clear_model();
    endtask

    typedef struct {
        logic req;
        logic shuf;
        logic ready;
        logic resh;
        logic valid;
    } vec_t;

    task automatic run_table();
        vec_t tbl[6];
        // shuffle+req together, then a draw with a shuffle arriving while busy
        tbl[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        for (int unsigned i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            bus.i_req     = tbl[i].req;
            bus.i_shuffle = tbl[i].shuf;
            @(negedge clk);
            chk($sformatf("vec%0d_ready", i), int'(bus.o_ready), int'(tbl[i].ready));
            chk($sformatf("vec%0d_resh", i), int'(bus.o_reshuffled), int'(tbl[i].resh));
            chk($sformatf("vec%0d_valid", i), int'(bus.o_card_valid), int'(tbl[i].valid));
            if (i == 2) chk("vec_remaining_after_shuffle", int'(bus.o_remaining), 52);
        end
        bus.i_req     = 1'b0;
        bus.i_shuffle = 1'b0;
        chk("vec_remaining_end", int'(bus.o_remaining), TRACK ? 51 : 52);
    endtask

    task automatic reset_test();
        int start, idx, k, tries;
        int min_k, rst_at;
        min_k  = TRACK ? 5 : 1;
        rst_at = TRACK ? 3 : 1;
        tries  = 0;
        do begin
            @(posedge clk); #1;
            start = start_of(m_lfsr);
            predict(start, idx, k);
            tries++;
        end while (k < min_k && tries < 300);
        if (k < min_k) begin
            checks++;
            errors++;
            $display("FAIL reset_setup: no long search found, k=%0d required>=%0d", k, min_k);
        end
        bus.i_req = 1'b1;
        @(posedge clk); #1;
        bus.i_req = 1'b0;
        for (int c = 1; c < rst_at; c++) begin
            @(negedge clk);
            chk("no_valid_before_reset", int'(bus.o_card_valid), 0);
            @(posedge clk); #1;
        end
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("reset_no_valid", int'(bus.o_card_valid), 0);
            chk("reset_ready", int'(bus.o_ready), 1);
            chk("reset_remaining", int'(bus.o_remaining), 52);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        clear_model();
        repeat (2) begin
            @(negedge clk);
            chk("post_reset_no_valid", int'(bus.o_card_valid), 0);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        bus.i_req     = 1'b0;
        bus.i_shuffle = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", int'(bus.o_ready), 1);
        chk("rst_remaining", int'(bus.o_remaining), 52);
        chk("rst_rank", int'(bus.o_rank), 0);
        chk("rst_suit", int'(bus.o_suit), 0);
        chk("rst_valid", int'(bus.o_card_valid), 0);
        chk("rst_resh", int'(bus.o_reshuffled), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (10) begin
            @(negedge clk);
            chk("idle_no_valid", int'(bus.o_card_valid), 0);
        end

`ifdef CARD_SHOE_TRACK_EN
        repeat (52) draw();  // empties the shoe
        draw();              // auto-reshuffle draw
        repeat (9) draw();   // 10 draws since the refill
`else
        repeat (100) draw();
`endif
        run_table();
        do_shuffle();
`ifdef CARD_SHOE_TRACK_EN
        repeat (51) draw();
`endif
        reset_test();
        draw();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
